// File: rtl/booth_operand_sequencer_if.sv
// Operand and result handshakes for booth_operand_sequencer.
// master: operand producer / result consumer; slave: the sequencer.
interface booth_operand_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_prod;

    modport master (
        output in_valid, in_a, in_b, res_ready,
        input  in_ready, res_valid, res_prod
    );

    modport slave (
        input  in_valid, in_a, in_b, res_ready,
        output in_ready, res_valid, res_prod
    );
endinterface

// File: rtl/booth_operand_sequencer.sv
// booth_operand_sequencer: feeds an 8x8 Booth multiplier, pulses START,
// waits MUL_LATENCY cycles, captures the 16-bit product and hands it over
// a valid/ready result port.
// Optional feature: define SEQ_ACCUM_EN to add a running signed product
// accumulator (acc) with a synchronous clear (acc_clr).
module booth_operand_sequencer #(
    parameter int unsigned MUL_LATENCY = 9,
    parameter int unsigned ACC_W       = 24
) (
    input  logic        clk,
    input  logic        rst,
    booth_operand_sequencer_if.slave bus,
    output logic [7:0]  M1,
    output logic [7:0]  M2,
    output logic        START,
    input  logic [15:0] mul_out,
    output logic        busy
`ifdef SEQ_ACCUM_EN
    ,
    input  logic             acc_clr,
    output logic [ACC_W-1:0] acc
`endif
);

    localparam int unsigned CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        STRT = 3'd2,
        WAIT = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Handshake readiness and busy are pure state decodes.
    assign bus.in_ready = (state == IDLE);
    assign busy         = (state != IDLE);

    // Sequencer FSM with registered operand, START and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            M1            <= 8'd0;
            M2            <= 8'd0;
            START         <= 1'b0;
            cnt           <= '0;
            bus.res_valid <= 1'b0;
            bus.res_prod  <= 16'd0;
        end else begin
            START <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        M1    <= bus.in_a;
                        M2    <= bus.in_b;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    START <= 1'b1;
                    state <= STRT;
                end
                STRT: begin
                    cnt   <= CNT_W'(MUL_LATENCY - 1);
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        bus.res_prod  <= mul_out;
                        bus.res_valid <= 1'b1;
                        state         <= DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (bus.res_valid && bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SEQ_ACCUM_EN
    logic             capture_c;
    logic [ACC_W-1:0] prod_ext_c;

    assign capture_c  = (state == WAIT) && (cnt == '0);
    assign prod_ext_c = ACC_W'($signed(mul_out));

    // Running sum of captured products; a clear landing on a capture keeps that product.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (acc_clr) begin
            acc <= capture_c ? prod_ext_c : '0;
        end else if (capture_c) begin
            acc <= acc + prod_ext_c;
        end
    end
`endif

endmodule

// File: tb/tb_booth_operand_sequencer.sv
// Testbench for booth_operand_sequencer: table-driven operand vectors with a
// result scoreboard, plus hand sequences for back-pressure, ignored input
// during WAIT, mid-operation reset and (when enabled) the accumulator.
module tb_booth_operand_sequencer;

    localparam int unsigned LAT = 9;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    booth_operand_sequencer_if bus ();

    logic [7:0]  M1;
    logic [7:0]  M2;
    logic        START;
    logic [15:0] mul_out;
    logic        busy;
`ifdef SEQ_ACCUM_EN
    logic        acc_clr;
    logic [23:0] acc;
`endif

    booth_operand_sequencer #(.MUL_LATENCY(LAT), .ACC_W(24)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .M1      (M1),
        .M2      (M2),
        .START   (START),
        .mul_out (mul_out),
        .busy    (busy)
`ifdef SEQ_ACCUM_EN
        ,
        .acc_clr (acc_clr),
        .acc     (acc)
`endif
    );

    // Multiplier stand-in: product valid only in the cycle before the
    // capture edge, junk at all other times.
    int          mcnt;
    logic [15:0] mprod;
    always @(posedge clk) begin
        if (rst)            mcnt <= 0;
        else if (START)     mcnt <= LAT;
        else if (mcnt > 0)  mcnt <= mcnt - 1;
    end
    assign mprod   = 16'($signed(M1) * $signed(M2));
    assign mul_out = (mcnt == 1) ? mprod : 16'hA5A5;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    vec_t        vecs[7];
    logic [15:0] sb[$];
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation; hold = cycles of result back-pressure,
    // poke = drive 7x7 during WAIT, clr_cap = pulse acc_clr on the capture edge.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                          input int hold, input bit poke, input bit clr_cap);
        int          n;
        logic [15:0] want;
        logic [15:0] held;
        bus.res_ready = (hold == 0);
        n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        sb.push_back(exp);
        tick();
        bus.in_valid = 1'b0;
        chk("M1_latched", 32'(M1), 32'(a));
        chk("M2_latched", 32'(M2), 32'(b));
        chk("busy_load", 32'(busy), 32'd1);
        chk("in_ready_load", 32'(bus.in_ready), 32'd0);
        chk("start_before", 32'(START), 32'd0);
        tick();
        chk("start_pulse", 32'(START), 32'd1);
        tick();
        chk("start_drop", 32'(START), 32'd0);
        if (poke) begin
            bus.in_valid = 1'b1;
            bus.in_a     = 8'd7;
            bus.in_b     = 8'd7;
        end
        n = 1;
        while (n <= 40) begin
`ifdef SEQ_ACCUM_EN
            if (clr_cap && n == LAT) acc_clr = 1'b1;
`endif
            tick();
            bus.in_valid = 1'b0;
`ifdef SEQ_ACCUM_EN
            acc_clr = 1'b0;
`endif
            if (poke && n == 1) begin
                chk("poke_M1_unchanged", 32'(M1), 32'(a));
                chk("poke_M2_unchanged", 32'(M2), 32'(b));
                chk("poke_in_ready", 32'(bus.in_ready), 32'd0);
            end
            if (bus.res_valid) break;
            n++;
        end
        chk("res_latency", 32'(n), 32'(LAT));
        if (sb.size() > 0) begin
            want = sb.pop_front();
            if (bus.res_valid) chk("res_prod", 32'(bus.res_prod), 32'(want));
        end
        held = bus.res_prod;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_res_valid", 32'(bus.res_valid), 32'd1);
            chk("hold_res_prod", 32'(bus.res_prod), 32'(held));
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.res_ready = 1'b1;
        tick();
        chk("consume_res_valid", 32'(bus.res_valid), 32'd0);
        chk("consume_in_ready", 32'(bus.in_ready), 32'd1);
        chk("consume_busy", 32'(busy), 32'd0);
        bus.res_ready = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_START"}, 32'(START), 32'd0);
        chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
        chk({tag, "_M1"}, 32'(M1), 32'd0);
        chk({tag, "_M2"}, 32'(M2), 32'd0);
`ifdef SEQ_ACCUM_EN
        chk({tag, "_acc"}, 32'(acc), 32'd0);
`endif
    endtask

    initial begin
        int seen;
        bus.in_valid  = 1'b0;
        bus.in_a      = 8'd0;
        bus.in_b      = 8'd0;
        bus.res_ready = 1'b0;
`ifdef SEQ_ACCUM_EN
        acc_clr = 1'b0;
`endif
        rst = 1'b1;
        tick();
        tick();
        chk_reset_state("reset");
        chk("reset_res_prod", 32'(bus.res_prod), 32'd0);
        rst = 1'b0;

        vecs[0] = '{8'd4,   8'd4,   16'h0010};
        vecs[1] = '{8'hFD,  8'd5,   16'hFFF1};
        vecs[2] = '{8'h80,  8'h80,  16'h4000};
        vecs[3] = '{8'd127, 8'h80,  16'hC080};
        vecs[4] = '{8'd0,   8'hFF,  16'h0000};
        vecs[5] = '{8'hFF,  8'hFF,  16'h0001};
        vecs[6] = '{8'd127, 8'd127, 16'h3F01};
        for (int i = 0; i < 7; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].exp, 0, 1'b0, 1'b0);

        // Result back-pressure for five cycles.
        run_op(8'd9, 8'hFE, 16'hFFEE, 5, 1'b0, 1'b0);
        // New operands offered mid-operation are ignored.
        run_op(8'd11, 8'd3, 16'h0021, 0, 1'b1, 1'b0);

        // Reset during WAIT aborts with no result.
        bus.in_valid = 1'b1;
        bus.in_a     = 8'd5;
        bus.in_b     = 8'd6;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("abort_in_wait_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_state("abort");
        bus.res_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.res_valid || START) seen++;
        end
        chk("abort_no_result", 32'(seen), 32'd0);
        bus.res_ready = 1'b0;

`ifdef SEQ_ACCUM_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run_op(8'd4, 8'd4, 16'h0010, 0, 1'b0, 1'b0);
        run_op(8'hFD, 8'd5, 16'hFFF1, 0, 1'b0, 1'b0);
        chk("acc_sum", 32'(acc), 32'h000001);
        run_op(8'd2, 8'd3, 16'h0006, 0, 1'b0, 1'b1);
        chk("acc_clr_on_capture", 32'(acc), 32'h000006);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/booth_operand_sequencer.md
# booth_operand_sequencer

Control stage directly upstream and downstream of `Booth_Multiplier`. It accepts 8-bit operand pairs over a valid/ready handshake and drives `M1`/`M2`. It issues a one-cycle `START` pulse, waits a fixed latency, captures the 16-bit product from `out`, and presents it over a valid/ready result handshake. This replaces hand-timed `START` stimulus with a reusable sequencer.

## Interface
- `MUL_LATENCY`, default 9: cycles from the end of the `START` cycle until `mul_out` is valid. Must be ≥1.
- `ACC_W`, default 24: accumulator width. Used only with `SEQ_ACCUM_EN`.

- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: sequencer can accept. Equals `state==IDLE`.
- `in_a` in 8: multiplicand, signed two's complement.
- `in_b` in 8: multiplier, signed two's complement.
- `M1` out 8: to multiplier `M1`. Registered and held stable for the whole operation.
- `M2` out 8: to multiplier `M2`. Registered and held stable.
- `START` out 1: to multiplier `START`. Registered, one-cycle pulse.
- `mul_out` in 16: from multiplier `out`.
- `res_valid` out 1: product available.
- `res_ready` in 1: consumer accepts the product.
- `res_prod` out 16: captured signed product.
- `busy` out 1: high in any state other than IDLE.
- `acc_clr` in 1: synchronous accumulator clear. Present only with `SEQ_ACCUM_EN`.
- `acc` out `ACC_W`: running signed sum of products. Present only with `SEQ_ACCUM_EN`.

## Operation
- States are IDLE, LOAD, STRT, WAIT and DONE.
- IDLE: if `in_valid`, latch `in_a`→`M1` and `in_b`→`M2`, then go to LOAD.
- LOAD: one settle cycle so operands are stable before `START`. Go to STRT.
- STRT: `START`=1 for this cycle only. Load the down-counter with `MUL_LATENCY-1`. Go to WAIT.
- WAIT: decrement the counter each cycle. When the counter is 0:
  - capture `mul_out`→`res_prod`;
  - set `res_valid`=1;
  - go to DONE.
- DONE: hold `res_valid` and `res_prod`. On `res_valid && res_ready`, clear `res_valid` and go to IDLE.
- `in_ready` is 0 outside IDLE. `in_valid` in other states is ignored and must not disturb `M1`/`M2`.
- `M1`/`M2` keep their last values after the operation until the next accept.
- `mul_out` is sampled only at the WAIT exit edge. Its value at all other times is don't-care.
- `rst` has priority over everything:
  - state→IDLE;
  - `M1`=`M2`=0, `START`=0, `res_valid`=0, `res_prod`=0, counter=0, `acc`=0;
  - after the reset edge, `in_ready`=1 and `busy`=0.
- Reset mid-operation (any state) aborts with no result. `START` is low from the reset edge.

## Timing
- Accept at edge k (IDLE and `in_valid`). Then:
  - state is LOAD in cycle k..k+1;
  - `START` is high in cycle k+1..k+2;
  - WAIT spans edges k+2 .. k+2+`MUL_LATENCY`.
- `res_valid` rises at edge k+2+`MUL_LATENCY`. With the default, that is edge k+11.
- If `res_ready` is already high, the result is consumed at the next edge and `in_ready` returns to 1. Minimum issue interval is `MUL_LATENCY`+4 cycles.
- No combinational path from inputs to outputs, except `in_ready`/`busy`, which decode state.

## Configuration
- `SEQ_ACCUM_EN` defined: `acc` and `acc_clr` exist.
  - At the capture edge, `acc` ← `acc` + sign-extended `mul_out`, wrapping modulo 2^`ACC_W`.
  - `acc_clr` alone sets `acc`=0.
  - `acc_clr` coincident with a capture sets `acc` = sign-extended product.
- `SEQ_ACCUM_EN` undefined: no accumulator logic and no `acc`/`acc_clr` ports. All other behaviour is identical.

## Test plan
- `in_a`=4, `in_b`=4, accepted at edge k → `START` high exactly in cycle k+1, `res_prod`=0x0010 with `res_valid` at edge k+11 (`MUL_LATENCY`=9).
- `in_a`=-3 (0xFD), `in_b`=5 → `res_prod`=0xFFF1. Separately, `in_a`=-128, `in_b`=-128 → `res_prod`=0x4000.
- `res_ready` held low for 5 cycles after `res_valid` → `res_prod`/`res_valid` stable, `in_ready`=0 throughout. Raise `res_ready` → `res_valid` clears at the next edge and `in_ready`=1.
- `in_valid` with new operands (7, 7) pulsed during WAIT → ignored. `M1`/`M2` unchanged and the result is from the original operands.
- `rst` asserted during WAIT → next edge: IDLE, `START`=0, `res_valid`=0, `M1`=`M2`=0, and no result is ever produced.
- `SEQ_ACCUM_EN` defined: products 4×4 then -3×5 → `acc`=0x000001. `acc_clr` coincident with a 2×3 capture → `acc`=0x000006.
